muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of instruction decode and alongside the ALU.
- Accepts an operation (funct3 of an OP-opcode instruction with funct7=0x01) plus two 32-bit operands, computes over multiple cycles, and returns a 32-bit result with a done pulse.
- The pipeline stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 52 +++++
 rtl/muldiv_signfix.sv | 49 ++++
 rtl/muldiv_unit.sv | 202 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the RV32M multiply/divide path. Decode uses the opcode,
// funct7 and funct3 values to generate `start`; muldiv_unit uses the state
// encodings, the latched-operation context and the signedness helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  // Instruction fields that select the M extension.
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

  // funct3 encodings of the eight M-extension operations.
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Operation context captured when start is accepted.
  typedef struct packed {
    logic [2:0] funct3;
    logic       neg_a;   // opA was a negative signed value
    logic       neg_b;   // opB was a negative signed value
  } op_ctx_t;

  function automatic logic is_div(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Purely combinational sign handling around the iterative datapath:
//   - front end: converts the raw operands into magnitudes and reports which
//     operands were negative (only when that operand is treated as signed);
//   - back end: conditionally negates the 64-bit product, the quotient and the
//     remainder produced from magnitudes.
// Ports:
//   op_a, op_b       raw operands          a_signed, b_signed  signedness
//   mag_a, mag_b     operand magnitudes    neg_a, neg_b        negative flags
//   prod_mag/neg     product in + negate   prod_fix            corrected product
//   quot_mag/neg     quotient in + negate  quot_fix            corrected quotient
//   rem_mag/neg      remainder in + negate rem_fix             corrected remainder
// -----------------------------------------------------------------------------
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [MD_XLEN-1:0]   op_a,
  input  logic [MD_XLEN-1:0]   op_b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  output logic [MD_XLEN-1:0]   mag_a,
  output logic [MD_XLEN-1:0]   mag_b,
  output logic                 neg_a,
  output logic                 neg_b,
  input  logic [2*MD_XLEN-1:0] prod_mag,
  input  logic                 prod_neg,
  output logic [2*MD_XLEN-1:0] prod_fix,
  input  logic [MD_XLEN-1:0]   quot_mag,
  input  logic                 quot_neg,
  output logic [MD_XLEN-1:0]   quot_fix,
  input  logic [MD_XLEN-1:0]   rem_mag,
  input  logic                 rem_neg,
  output logic [MD_XLEN-1:0]   rem_fix
);

  assign neg_a = a_signed & op_a[MD_XLEN-1];
  assign neg_b = b_signed & op_b[MD_XLEN-1];

  // The most negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(XLEN-1).
  assign mag_a = neg_a ? (~op_a + 1'b1) : op_a;
  assign mag_b = neg_b ? (~op_b + 1'b1) : op_b;

  assign prod_fix = prod_neg ? (~prod_mag + 1'b1) : prod_mag;
  assign quot_fix = quot_neg ? (~quot_mag + 1'b1) : quot_mag;
  assign rem_fix  = rem_neg  ? (~rem_mag  + 1'b1) : rem_mag;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage.
//
// Handshake: `start` is sampled only while the unit is idle (and not flushed);
// from the following cycle `busy` stays high through the cycle in which `done`
// pulses, so decode stalls on (start & idle) | busy. `result` is valid when
// `done` is high and is held until a later operation completes. No queueing:
// start while busy is dropped.
//
// Ports:
//   CLK     rising-edge clock        nrst    async active-low reset
//   start   operation request        funct3  M-extension op select
//   opA     rs1 value                opB     rs2 value
//   flush   abort in-flight op       busy    unit occupied (registered)
//   done    one-cycle result strobe  result  32-bit result
//
// Datapath: one 64-bit accumulator shared by both operations.
//   multiply: acc = {partial_hi, multiplier}; each step adds the multiplicand
//             to the high half when acc[0] is set, then shifts right.
//   divide:   acc = {remainder, dividend}; each step shifts left and
//             subtracts the divisor when it fits, setting the quotient bit.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]        state_q,  state_d;
  op_ctx_t           ctx_q,    ctx_d;
  logic [4:0]        cnt_q,    cnt_d;
  logic [XLEN-1:0]   b_q,      b_d;
  logic [2*XLEN-1:0] acc_q,    acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  // Sign handling
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_a, neg_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  muldiv_signfix u_signfix (
    .op_a     (opA),
    .op_b     (opB),
    .a_signed (op_a_signed(funct3)),
    .b_signed (op_b_signed(funct3)),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_a    (neg_a),
    .neg_b    (neg_b),
    .prod_mag (acc_q),
    .prod_neg (ctx_q.neg_a ^ ctx_q.neg_b),
    .prod_fix (prod_fix),
    .quot_mag (acc_q[XLEN-1:0]),
    .quot_neg (ctx_q.neg_a ^ ctx_q.neg_b),
    .quot_fix (quot_fix),
    .rem_mag  (acc_q[2*XLEN-1:XLEN]),
    .rem_neg  (ctx_q.neg_a),
    .rem_fix  (rem_fix)
  );

  // Divide special cases resolved directly from the request.
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_val;

  always_comb begin
    div_by_zero = is_div(funct3) && (opB == '0);
    div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == '1);
    special_val = '0;
    if (div_by_zero) begin
      // funct3[1] distinguishes REM/REMU from DIV/DIVU
      special_val = funct3[1] ? opA : '1;
    end else if (div_ovf) begin
      special_val = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One iteration step for each operation.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] div_shift;
  logic [XLEN:0]     div_rem_ext;   // shifted remainder incl. the bit shifted out
  logic              div_fits;
  logic [XLEN-1:0]   div_sub;

  always_comb begin
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift   = {acc_q[2*XLEN-2:0], 1'b0};
    div_rem_ext = acc_q[2*XLEN-1:XLEN-1];
    div_fits    = div_rem_ext >= {1'b0, b_q};
    // When it fits the difference is below the divisor, so XLEN bits suffice.
    div_sub     = div_rem_ext[XLEN-1:0] - b_q;
  end

  // FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    ctx_d    = ctx_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          ctx_d.funct3 = funct3;
          ctx_d.neg_a  = neg_a;
          ctx_d.neg_b  = neg_b;
          cnt_d        = '0;
          b_d          = mag_b;
          acc_d        = {{XLEN{1'b0}}, mag_a};
          if (div_by_zero || div_ovf) begin
            result_d = special_val;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div(ctx_q.funct3)) begin
            acc_d = div_fits ? {div_sub, div_shift[XLEN-1:1], 1'b1} : div_shift;
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          case (ctx_q.funct3)
            F3_MUL:                   result_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU,
            F3_MULHU:                 result_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:          result_d = quot_fix;
            default:                  result_d = rem_fix;
          endcase
          state_d = ST_DONE;
        end
      end

      // The result has already retired, so flush cannot cancel the pulse.
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      ctx_q    <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctx_q    <= ctx_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. Cycle T is the edge that accepts start;
// "cycle T+k" is the interval after edge T+k-1, observed at its falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        CLK    = 1'b0;
  logic        nrst   = 1'b0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opA    = '0;
  logic [31:0] opB    = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          errors   = 0;
  int          checks   = 0;
  logic [31:0] prev_res = '0;

  // Clock / reset
  always #5 CLK = ~CLK;

  muldiv_unit #(.XLEN(32)) dut (
    .CLK    (CLK),
    .nrst   (nrst),
    .start  (start),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Driver: called at a falling edge; start is accepted on the next rising edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    opA    = a;
    opB    = b;
    start  = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  // Waits for done, checking latency, busy, result hold and the final result.
  // poke>0 drives a stray start (a div-by-zero that would finish at once) in
  // that cycle, which the busy unit must ignore.
  task automatic wait_done(input string tag, input logic [31:0] exp,
                           input int exp_lat, input int poke);
    int lat     = -1;
    bit busy_ok = 1'b1;
    bit held_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (result !== prev_res) held_ok = 1'b0;
      if (poke > 0 && k == poke) begin
        start = 1'b1; funct3 = F3_DIVU; opA = 32'd9; opB = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    if (exp_lat > 1) check({tag, "_held"}, {31'd0, held_ok}, 32'd1);
    check({tag, "_result"}, result, exp);
    @(negedge CLK);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    prev_res = exp;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    repeat (2) @(negedge CLK);
    nrst = 1'b1;
    @(negedge CLK);

    // Multiplies (first one also sees a stray start while busy)
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done("mul_7_m3", 32'hFFFF_FFEB, 34, 5);
    issue(F3_MULH, 32'h8000_0000, 32'h8000_0000);
    wait_done("mulh_min_min", 32'h4000_0000, 34, 0);
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhu_max", 32'hFFFF_FFFE, 34, 0);
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulhsu_m1_max", 32'hFFFF_FFFF, 34, 0);

    // Divides
    issue(F3_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 32'hFFFF_FFFD, 34, 0);
    issue(F3_REM, 32'hFFFF_FFF9, 32'd2);
    wait_done("rem_m7_2", 32'hFFFF_FFFF, 34, 0);
    issue(F3_DIVU, 32'd100, 32'd7);
    wait_done("divu_100_7", 32'd14, 34, 0);
    issue(F3_REMU, 32'd100, 32'd7);
    wait_done("remu_100_7", 32'd2, 34, 0);
    issue(F3_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", 32'hFFFF_FFFD, 34, 0);
    issue(F3_REM, 32'd7, 32'hFFFF_FFFE);
    wait_done("rem_7_m2", 32'd1, 34, 0);
    issue(F3_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    wait_done("divu_big", 32'd1, 34, 0);
    issue(F3_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    wait_done("remu_big", 32'd1, 34, 0);

    // Divide special cases
    issue(F3_DIV, 32'd5, 32'd0);
    wait_done("div_by0", 32'hFFFF_FFFF, 1, 0);
    issue(F3_REM, 32'd5, 32'd0);
    wait_done("rem_by0", 32'd5, 1, 0);
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 32'h8000_0000, 1, 0);
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("rem_ovf", 32'd0, 1, 0);

    // Flush during CALC at cycle T+10
    begin
      bit no_done = 1'b1;
      issue(F3_MUL, 32'd3, 32'd5);
      for (int k = 1; k <= 10; k++) begin
        @(negedge CLK);
        if (done) no_done = 1'b0;
      end
      flush = 1'b1;
      @(posedge CLK);
      #1 flush = 1'b0;
      @(negedge CLK);
      check("flush_calc_no_done", {31'd0, no_done}, 32'd1);
      check("flush_calc_busy", {31'd0, busy}, 32'd0);
      check("flush_calc_done", {31'd0, done}, 32'd0);
      check("flush_calc_result", result, prev_res);
      issue(F3_DIVU, 32'd100, 32'd7);
      wait_done("after_flush", 32'd14, 34, 0);
    end

    // start and flush together in IDLE: not accepted
    begin
      bit stray = 1'b0;
      funct3 = F3_DIV; opA = 32'd1; opB = 32'd0;
      start = 1'b1; flush = 1'b1;
      @(posedge CLK);
      #1 begin start = 1'b0; flush = 1'b0; end
      for (int k = 1; k <= 3; k++) begin
        @(negedge CLK);
        if (busy || done) stray = 1'b1;
      end
      check("start_flush_ignored", {31'd0, stray}, 32'd0);
      check("start_flush_result", result, prev_res);
    end

    // flush in DONE does not cancel the pulse
    issue(F3_DIV, 32'd5, 32'd0);
    @(negedge CLK);
    check("flush_done_pulse", {31'd0, done}, 32'd1);
    flush = 1'b1;
    @(posedge CLK);
    #1 flush = 1'b0;
    @(negedge CLK);
    check("flush_done_after", {30'd0, busy, done}, 32'd0);
    check("flush_done_result", result, 32'hFFFF_FFFF);
    prev_res = 32'hFFFF_FFFF;

    // Reset mid-CALC
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (8) @(negedge CLK);
    nrst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    @(negedge CLK);
    nrst = 1'b1;
    @(negedge CLK);
    prev_res = 32'd0;
    issue(F3_MUL, 32'd6, 32'd7);
    wait_done("after_reset", 32'd42, 34, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
